agc_rupt_sched: RTL and testbench

- Schedules external interrupt-request stimulus (keyboard, mark, uplink, radar, hand controller) into the AGC's rupt inputs.
- One fixed-width pulse at a time, with a minimum gap between pulses; held off by MNHRPT.
- Sits in the simulation harness between stimulus sources and the agc / fpga_agc top.
- Replaces ad-hoc timed pulses with a sequenced, arbitrated requester.

---
 rtl/agc_sim_pkg.sv | 24 ++
 rtl/agc_rupt_sched_if.sv | 29 ++
 rtl/agc_req_sync.sv | 30 +++
 rtl/agc_rupt_sched.sv | 106 ++++++++++
 tb/tb_agc_rupt_sched.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/agc_sim_pkg.sv
// Shared definitions for the AGC simulation harness: rupt indices, scheduler states
// and the fixed-priority pick used by the rupt scheduler.
package agc_sim_pkg;

    localparam int NRUPT    = 6;
    localparam int RUPT_KY1 = 0;
    localparam int RUPT_KY2 = 1;
    localparam int RUPT_MK  = 2;
    localparam int RUPT_UP  = 3;
    localparam int RUPT_RAD = 4;
    localparam int RUPT_HND = 5;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } sched_state_t;

    // Isolates the lowest set bit, so the lowest index always wins.
    function automatic logic [NRUPT-1:0] pick_lowest(input logic [NRUPT-1:0] req);
        return req & (~req + NRUPT'(1));
    endfunction

endpackage

// File: rtl/agc_rupt_sched_if.sv
// Stimulus-side and AGC-side signals of the rupt scheduler, bundled as one interface.
// The harness drives requests through master; the scheduler answers through slave.
interface agc_rupt_sched_if;
    import agc_sim_pkg::*;

    logic [NRUPT-1:0] REQ_IN;
    logic             MNHRPT;
    logic             OVF_CLR;
    logic             KYRPT1;
    logic             KYRPT2;
    logic             MKRPT;
    logic             UPRUPT;
    logic             RADRPT;
    logic             HNDRPT;
    logic [NRUPT-1:0] PEND;
    logic [NRUPT-1:0] OVF;
    logic             BUSY;

    modport master (
        output REQ_IN, MNHRPT, OVF_CLR,
        input  KYRPT1, KYRPT2, MKRPT, UPRUPT, RADRPT, HNDRPT, PEND, OVF, BUSY
    );

    modport slave (
        input  REQ_IN, MNHRPT, OVF_CLR,
        output KYRPT1, KYRPT2, MKRPT, UPRUPT, RADRPT, HNDRPT, PEND, OVF, BUSY
    );

endinterface

// File: rtl/agc_req_sync.sv
// Per-bit 2-flop synchronizer plus edge register; rise is a one-cycle pulse.
// Latency: an input sampled high at edge 1 shows as rise after edge 2. No backpressure.
module agc_req_sync #(
    parameter int W = 6
) (
    input  logic         SIM_CLK,
    input  logic         SIM_RST_n,
    input  logic [W-1:0] async_in,
    output logic [W-1:0] rise
);

    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic [W-1:0] s3;

    always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
        if (!SIM_RST_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/agc_rupt_sched.sv
// Arbitrated rupt requester: one PULSE_TICKS-wide pulse at a time, GAP_TICKS idle after.
// Latency: request rise -> PEND after edge 3, rupt after edge 4; MNHRPT holds off new grants only.
module agc_rupt_sched
    import agc_sim_pkg::*;
#(
    parameter int PULSE_TICKS = 2,
    parameter int GAP_TICKS   = 4,
    parameter int CNT_W       = 8
) (
    input  logic             SIM_CLK,
    input  logic             SIM_RST_n,
    input  logic             TICK,
    agc_rupt_sched_if.slave  bus
);

    sched_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NRUPT-1:0] rupt_q, rupt_d;
    logic [NRUPT-1:0] pend_q, pend_d;
    logic [NRUPT-1:0] ovf_q, ovf_d;
    logic [NRUPT-1:0] rise;
    logic [NRUPT-1:0] grant;
    logic             can_grant;

    agc_req_sync #(.W(NRUPT)) u_sync (
        .SIM_CLK   (SIM_CLK),
        .SIM_RST_n (SIM_RST_n),
        .async_in  (bus.REQ_IN),
        .rise      (rise)
    );

    // The final GAP tick doubles as the idle slot, so grants are PULSE+GAP ticks apart.
    assign can_grant = TICK && (|pend_q) && !bus.MNHRPT &&
                       ((state_q == IDLE) || ((state_q == GAP) && (cnt_q == '0)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rupt_d  = rupt_q;
        grant   = '0;

        if (can_grant) begin
            grant   = pick_lowest(pend_q);
            rupt_d  = grant;
            cnt_d   = CNT_W'(PULSE_TICKS - 1);
            state_d = PULSE;
        end else if (TICK) begin
            case (state_q)
                PULSE: begin
                    if (cnt_q == '0) begin
                        rupt_d = '0;
                        if (GAP_TICKS > 0) begin
                            cnt_d   = CNT_W'(GAP_TICKS - 1);
                            state_d = GAP;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        // A rise landing on the granting cycle re-arms the bit as a fresh request.
        pend_d = (pend_q & ~grant) | rise;
        ovf_d  = (bus.OVF_CLR ? '0 : ovf_q) | (rise & pend_q & ~grant);
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
        if (!SIM_RST_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rupt_q  <= '0;
            pend_q  <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rupt_q  <= rupt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.KYRPT1 = rupt_q[RUPT_KY1];
    assign bus.KYRPT2 = rupt_q[RUPT_KY2];
    assign bus.MKRPT  = rupt_q[RUPT_MK];
    assign bus.UPRUPT = rupt_q[RUPT_UP];
    assign bus.RADRPT = rupt_q[RUPT_RAD];
    assign bus.HNDRPT = rupt_q[RUPT_HND];
    assign bus.PEND   = pend_q;
    assign bus.OVF    = ovf_q;
    assign bus.BUSY   = (state_q != IDLE);

endmodule

// File: tb/tb_agc_rupt_sched.sv
// Directed bench: dut_a uses default timing, dut_b uses PULSE_TICKS=3, GAP_TICKS=0 with slow TICK.
// Inputs change just after the falling edge; outputs are sampled at the following falling edge.
module tb_agc_rupt_sched;

    logic clk = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    logic tick_a = 1'b1;
    logic tick_b = 1'b0;
    int   passed = 0;
    int   total  = 0;
    int   ph     = 0;
    int   width  = 0;

    always #5 clk = ~clk;

    agc_rupt_sched_if ia ();
    agc_rupt_sched_if ib ();

    agc_rupt_sched dut_a (
        .SIM_CLK   (clk),
        .SIM_RST_n (rst_a_n),
        .TICK      (tick_a),
        .bus       (ia.slave)
    );

    agc_rupt_sched #(.PULSE_TICKS(3), .GAP_TICKS(0), .CNT_W(8)) dut_b (
        .SIM_CLK   (clk),
        .SIM_RST_n (rst_b_n),
        .TICK      (tick_b),
        .bus       (ib.slave)
    );

    wire [5:0] ra = {ia.HNDRPT, ia.RADRPT, ia.UPRUPT, ia.MKRPT, ia.KYRPT2, ia.KYRPT1};
    wire [5:0] rb = {ib.HNDRPT, ib.RADRPT, ib.UPRUPT, ib.MKRPT, ib.KYRPT2, ib.KYRPT1};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Each call advances one rising edge and returns at the following falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Same, with tick_b high on every fourth rising edge.
    task automatic cyc_b(input int n);
        repeat (n) begin
            tick_b = (ph == 0);
            ph = (ph + 1) % 4;
            @(negedge clk);
        end
    endtask

    initial begin
        ia.REQ_IN = 6'h3F; ia.MNHRPT = 1'b0; ia.OVF_CLR = 1'b0;
        ib.REQ_IN = 6'h00; ib.MNHRPT = 1'b0; ib.OVF_CLR = 1'b0;

        // Reset held with every request asserted.
        cyc(4);
        chk("rst_rupts", {2'b0, ra}, 8'h00);
        chk("rst_pend", {2'b0, ia.PEND}, 8'h00);
        chk("rst_ovf", {2'b0, ia.OVF}, 8'h00);
        chk("rst_busy", {7'b0, ia.BUSY}, 8'h00);
        chk("rst_b_rupts", {2'b0, rb}, 8'h00);

        rst_a_n = 1'b1;
        cyc(3);
        chk("t1_pend_e3", {2'b0, ia.PEND}, 8'h3F);
        chk("t1_rupts_e3", {2'b0, ra}, 8'h00);
        cyc(1);
        chk("t1_ky1_e4", {2'b0, ra}, 8'h01);
        chk("t1_pend_e4", {2'b0, ia.PEND}, 8'h3E);
        chk("t1_busy_e4", {7'b0, ia.BUSY}, 8'h01);
        cyc(1);
        chk("t1_ky1_e5", {2'b0, ra}, 8'h01);
        cyc(1);
        chk("t1_drop_e6", {2'b0, ra}, 8'h00);
        cyc(3);
        chk("t1_gap_e9", {2'b0, ra}, 8'h00);
        cyc(1);
        chk("t1_ky2_e10", {2'b0, ra}, 8'h02);
        #2 rst_a_n = 1'b0;
        #1 chk("t1_async_rst", {2'b0, ra}, 8'h00);
        chk("t1_rst_pend", {2'b0, ia.PEND}, 8'h00);
        ia.REQ_IN = 6'h00;
        cyc(2);
        rst_a_n = 1'b1;
        cyc(3);

        // Priority: RADRPT and HNDRPT rise together.
        ia.REQ_IN = 6'b110000;
        cyc(3);
        chk("t2_pend_e3", {2'b0, ia.PEND}, 8'h30);
        cyc(1);
        chk("t2_rad_e4", {2'b0, ra}, 8'h10);
        chk("t2_pend_e4", {2'b0, ia.PEND}, 8'h20);
        cyc(2);
        chk("t2_drop_e6", {2'b0, ra}, 8'h00);
        cyc(3);
        chk("t2_gap_e9", {2'b0, ra}, 8'h00);
        cyc(1);
        chk("t2_hnd_e10", {2'b0, ra}, 8'h20);
        chk("t2_pend_e10", {2'b0, ia.PEND}, 8'h00);
        cyc(2);
        chk("t2_hnd_drop_e12", {2'b0, ra}, 8'h00);
        cyc(3);
        chk("t2_busy_e15", {7'b0, ia.BUSY}, 8'h01);
        cyc(1);
        chk("t2_idle_e16", {7'b0, ia.BUSY}, 8'h00);

        // Inhibit holds off a pending MKRPT.
        ia.MNHRPT = 1'b1;
        ia.REQ_IN = 6'h04;
        cyc(6);
        chk("t3_pend_inh", {2'b0, ia.PEND}, 8'h04);
        chk("t3_rupts_inh", {2'b0, ra}, 8'h00);
        ia.MNHRPT = 1'b0;
        cyc(1);
        chk("t3_mk_grant", {2'b0, ra}, 8'h04);
        chk("t3_pend_clr", {2'b0, ia.PEND}, 8'h00);
        cyc(10);

        // Inhibit raised mid-pulse neither truncates it nor allows a new grant.
        ia.REQ_IN = 6'h08;
        cyc(4);
        chk("t4_up_e4", {2'b0, ra}, 8'h08);
        ia.MNHRPT = 1'b1;
        ia.REQ_IN = 6'h09;
        cyc(1);
        chk("t4_up_held", {2'b0, ra}, 8'h08);
        cyc(1);
        chk("t4_up_drop", {2'b0, ra}, 8'h00);
        cyc(10);
        chk("t4_no_grant", {2'b0, ra}, 8'h00);
        chk("t4_pend", {2'b0, ia.PEND}, 8'h01);
        ia.MNHRPT = 1'b0;
        cyc(1);
        chk("t4_resume", {2'b0, ra}, 8'h01);
        cyc(10);

        // Overflow: KYRPT2 rises twice while the first request is still pending.
        ia.REQ_IN = 6'h00;
        cyc(4);
        chk("t5_ovf_init", {2'b0, ia.OVF}, 8'h00);
        ia.REQ_IN = 6'h01;
        cyc(4);
        chk("t5_ky1", {2'b0, ra}, 8'h01);
        ia.REQ_IN = 6'h03;
        cyc(1);
        ia.REQ_IN = 6'h01;
        cyc(1);
        ia.REQ_IN = 6'h03;
        cyc(3);
        chk("t5_ovf_set", {2'b0, ia.OVF}, 8'h02);
        chk("t5_pend_set", {2'b0, ia.PEND}, 8'h02);
        cyc(1);
        chk("t5_ky2", {2'b0, ra}, 8'h02);
        chk("t5_pend_clr", {2'b0, ia.PEND}, 8'h00);
        cyc(2);
        chk("t5_ky2_drop", {2'b0, ra}, 8'h00);
        width = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (ra != 6'h00) width++;
        end
        chk("t5_single_pulse", width[7:0], 8'h00);
        ia.OVF_CLR = 1'b1;
        cyc(1);
        ia.OVF_CLR = 1'b0;
        chk("t5_ovf_clr", {2'b0, ia.OVF}, 8'h00);

        // A new overflow on the same edge as OVF_CLR is kept.
        ia.MNHRPT = 1'b1;
        ia.REQ_IN = 6'h00;
        cyc(3);
        ia.REQ_IN = 6'h04;
        cyc(1);
        ia.REQ_IN = 6'h00;
        cyc(1);
        ia.REQ_IN = 6'h04;
        cyc(1);
        chk("t5b_pend", {2'b0, ia.PEND}, 8'h04);
        cyc(1);
        ia.OVF_CLR = 1'b1;
        cyc(1);
        chk("t5b_set_wins", {2'b0, ia.OVF}, 8'h04);
        cyc(1);
        ia.OVF_CLR = 1'b0;
        chk("t5b_clr_next", {2'b0, ia.OVF}, 8'h00);
        chk("t5b_pend_kept", {2'b0, ia.PEND}, 8'h04);

        // Slow TICK, PULSE_TICKS=3, no gap; async reset mid-pulse.
        rst_b_n = 1'b1;
        ib.REQ_IN = 6'h03;
        ph = 0;
        cyc_b(4);
        chk("t6_pend", {2'b0, ib.PEND}, 8'h03);
        chk("t6_wait_tick", {2'b0, rb}, 8'h00);
        width = 0;
        for (int i = 0; i < 16; i++) begin
            cyc_b(1);
            if (rb[0]) width++;
        end
        chk("t6_width", width[7:0], 8'd12);
        chk("t6_low_e20", {2'b0, rb}, 8'h00);
        chk("t6_idle_e20", {7'b0, ib.BUSY}, 8'h00);
        cyc_b(1);
        chk("t6_ky2_e21", {2'b0, rb}, 8'h02);
        cyc_b(2);
        chk("t6_ky2_held", {2'b0, rb}, 8'h02);
        #2 rst_b_n = 1'b0;
        #1 chk("t6_async_rst", {2'b0, rb}, 8'h00);
        chk("t6_rst_busy", {7'b0, ib.BUSY}, 8'h00);
        cyc(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
